// File: rtl/uc_soma.sv
// Control unit for the float adder: sequences alignment check, normalize loop,
// rounding and one post-round renormalize, with a start/done handshake.
module uc_soma #(
    parameter int N_exp     = 8,
    parameter int N_mant    = 23,
    parameter int MAX_SHIFT = 25,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_exp-1:0] diferenca_exp,
    input  logic [1:0]       antes_virgula,
    output logic [1:0]       sel_mux_normalizer,
    output logic [1:0]       sel_normalizer,
    output logic             busy,
    output logic             done,
    output logic             load_result,
    output logic             big_diff,
    output logic             zero_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_NORM_FIRST,
        S_NORM_LOOP,
        S_ROUND,
        S_RENORM,
        S_DONE
    } state_t;

    localparam logic [1:0] MUX_ALU      = 2'b00;
    localparam logic [1:0] MUX_FEEDBACK = 2'b01;
    localparam logic [1:0] MUX_ROUND    = 2'b10;

    localparam logic [1:0] NORM_PASS  = 2'b00;
    localparam logic [1:0] NORM_RIGHT = 2'b01;
    localparam logic [1:0] NORM_LEFT  = 2'b10;

    localparam logic [N_exp:0]   BIG_LIMIT  = (N_exp+1)'(N_mant + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_SHIFT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MAX_SHIFT - 1);

    state_t           state;
    logic [CNT_W-1:0] shift_cnt;
    logic [N_exp-1:0] diff_mag;
    logic             is_big;
    logic             shift_left;
    logic [CNT_W-1:0] shift_cnt_next;

    // Unary minus of the most negative value wraps to itself, which read
    // as unsigned is exactly its magnitude.
    assign diff_mag = diferenca_exp[N_exp-1] ? -diferenca_exp : diferenca_exp;
    assign is_big   = {1'b0, diff_mag} > BIG_LIMIT;

    assign shift_left     = antes_virgula == 2'b00;
    assign shift_cnt_next = (shift_cnt == CNT_MAX) ? shift_cnt : shift_cnt + CNT_W'(1);

    // Normalizer shift select is Mealy: it follows antes_virgula in the same cycle.
    always_comb begin
        sel_normalizer = NORM_PASS;
        case (state)
            S_NORM_FIRST, S_NORM_LOOP: begin
                if (antes_virgula[1])
                    sel_normalizer = NORM_RIGHT;
                else if (antes_virgula[0])
                    sel_normalizer = NORM_PASS;
                else
                    sel_normalizer = NORM_LEFT;
            end
            S_ROUND: begin
                if (antes_virgula[1])
                    sel_normalizer = NORM_RIGHT;
            end
            default: sel_normalizer = NORM_PASS;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            shift_cnt          <= '0;
            sel_mux_normalizer <= MUX_ALU;
            busy               <= 1'b0;
            done               <= 1'b0;
            load_result        <= 1'b0;
            big_diff           <= 1'b0;
            zero_result        <= 1'b0;
        end else begin
            done        <= 1'b0;
            load_result <= 1'b0;
            case (state)
                S_IDLE: begin
                    sel_mux_normalizer <= MUX_ALU;
                    if (start) begin
                        state       <= S_ALIGN;
                        busy        <= 1'b1;
                        big_diff    <= 1'b0;
                        zero_result <= 1'b0;
                        shift_cnt   <= '0;
                    end
                end
                S_ALIGN: begin
                    if (is_big)
                        big_diff <= 1'b1;
                    state              <= S_NORM_FIRST;
                    sel_mux_normalizer <= MUX_ALU;
                end
                S_NORM_FIRST: begin
                    if (shift_left)
                        shift_cnt <= shift_cnt_next;
                    if (antes_virgula == 2'b01) begin
                        state              <= S_ROUND;
                        sel_mux_normalizer <= MUX_ROUND;
                    end else begin
                        state              <= S_NORM_LOOP;
                        sel_mux_normalizer <= MUX_FEEDBACK;
                    end
                end
                S_NORM_LOOP: begin
                    if (shift_left)
                        shift_cnt <= shift_cnt_next;
                    if (antes_virgula == 2'b01) begin
                        state              <= S_ROUND;
                        sel_mux_normalizer <= MUX_ROUND;
                    end else if (shift_left && shift_cnt == CNT_LAST) begin
                        // This cycle performs the final permitted left shift.
                        zero_result        <= 1'b1;
                        state              <= S_DONE;
                        sel_mux_normalizer <= MUX_FEEDBACK;
                        done               <= 1'b1;
                        load_result        <= 1'b1;
                    end
                end
                S_ROUND: begin
                    sel_mux_normalizer <= MUX_FEEDBACK;
                    if (antes_virgula[1]) begin
                        state <= S_RENORM;
                    end else begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        load_result <= 1'b1;
                    end
                end
                S_RENORM: begin
                    state              <= S_DONE;
                    sel_mux_normalizer <= MUX_FEEDBACK;
                    done               <= 1'b1;
                    load_result        <= 1'b1;
                end
                S_DONE: begin
                    state              <= S_IDLE;
                    sel_mux_normalizer <= MUX_ALU;
                    busy               <= 1'b0;
                end
                default: begin
                    state              <= S_IDLE;
                    sel_mux_normalizer <= MUX_ALU;
                    busy               <= 1'b0;
                end
            endcase
        end
    end

endmodule
